mem_req_ctrl: RTL and testbench

MEM_REQ_CTRL -- requirements
Module: mem_req_ctrl

---
 rtl/mem_req_ctrl_if.sv | 37 +++
 rtl/mem_req_ctrl.sv | 67 ++++++
 tb/tb_mem_req_ctrl.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/mem_req_ctrl_if.sv
// mem_req_ctrl_if: pipeline request/response and cache memory bus bundle
interface mem_req_ctrl_if;
  logic        req_valid;
  logic        req_wr;
  logic [15:0] req_addr;
  logic [15:0] req_wdata;
  logic        dump_req;
  logic        req_ready;
  logic        pipe_stall;
  logic        resp_valid;
  logic [15:0] resp_rdata;
  logic        resp_err;
  logic [15:0] hit_cnt;
  logic [15:0] miss_cnt;
  logic [15:0] Addr;
  logic [15:0] DataIn;
  logic        Rd;
  logic        Wr;
  logic        createdump;
  logic [15:0] DataOut;
  logic        Done;
  logic        Stall;
  logic        CacheHit;
  logic        err;
  modport slave (
    input  req_valid, req_wr, req_addr, req_wdata, dump_req,
    input  DataOut, Done, Stall, CacheHit, err,
    output req_ready, pipe_stall, resp_valid, resp_rdata, resp_err, hit_cnt, miss_cnt,
    output Addr, DataIn, Rd, Wr, createdump
  );
  modport master (
    output req_valid, req_wr, req_addr, req_wdata, dump_req,
    output DataOut, Done, Stall, CacheHit, err,
    input  req_ready, pipe_stall, resp_valid, resp_rdata, resp_err, hit_cnt, miss_cnt,
    input  Addr, DataIn, Rd, Wr, createdump
  );
endinterface

// File: rtl/mem_req_ctrl.sv
// mem_req_ctrl: sequences one pipeline memory request at a time onto the cache bus
module mem_req_ctrl #(
  parameter int TIMEOUT = 64
) (
  input logic clk,
  input logic rst,
  mem_req_ctrl_if.slave bus
);
  localparam int CW = (TIMEOUT > 64) ? $clog2(TIMEOUT) : 6;
  localparam logic [CW-1:0] TMAX = CW'(TIMEOUT - 1);
  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, RESP = 2'd2} state_t;
  state_t state, nxt;
  logic wr_l, err_q;
  logic [15:0] addr_l, wdata_l, rdata_q, hit_q, miss_q;
  logic [CW-1:0] cnt;
  logic accept, busy_exit;
  assign accept = state == IDLE && bus.req_valid;
  assign busy_exit = state == BUSY && (bus.Done || bus.err || cnt == TMAX);
  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= nxt;
  // next-state: misaligned requests skip the memory and answer with an error
  always_comb begin
    nxt = state == IDLE ? (bus.req_valid ? (bus.req_addr[0] ? RESP : BUSY) : IDLE) :
          state == BUSY ? (busy_exit ? RESP : BUSY) : IDLE;
  end
  // outputs: strobes decode from state so reset drops them immediately
  always_comb begin
    bus.req_ready  = state == IDLE;
    bus.pipe_stall = state == BUSY || accept;
    bus.resp_valid = state == RESP;
    bus.Rd         = state == BUSY && !wr_l;
    bus.Wr         = state == BUSY && wr_l;
    bus.Addr       = addr_l;
    bus.DataIn     = wdata_l;
    bus.createdump = bus.dump_req;
    bus.resp_rdata = rdata_q;
    bus.resp_err   = err_q;
    bus.hit_cnt    = hit_q;
    bus.miss_cnt   = miss_q;
  end
  // request latch, timeout counter, response data and statistics
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_l    <= 1'b0;
      addr_l  <= '0;
      wdata_l <= '0;
      cnt     <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      hit_q   <= '0;
      miss_q  <= '0;
    end else begin
      if (accept) begin
        wr_l    <= bus.req_wr;
        addr_l  <= bus.req_addr;
        wdata_l <= bus.req_wdata;
      end
      cnt <= state == BUSY ? cnt + 1'b1 : '0;
      if (accept && bus.req_addr[0]) err_q <= 1'b1;
      if (busy_exit) err_q <= bus.Done ? bus.err : 1'b1;
      if (state == BUSY && bus.Done && !wr_l) rdata_q <= bus.DataOut;
      if (state == BUSY && bus.Done && !bus.err && bus.CacheHit && hit_q != 16'hFFFF) hit_q <= hit_q + 1'b1;
      if (state == BUSY && bus.Done && !bus.err && !bus.CacheHit && miss_q != 16'hFFFF) miss_q <= miss_q + 1'b1;
    end
endmodule

// File: tb/tb_mem_req_ctrl.sv
// tb_mem_req_ctrl: directed checks of the memory request controller
module tb_mem_req_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int passed = 0;
  int total = 0;
  mem_req_ctrl_if bus();
  mem_req_ctrl #(.TIMEOUT(64)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %h want %h", tag, obs, exp);
  endtask
  task automatic xfer(input logic wr, input logic [15:0] a, input logic [15:0] wd,
                      input logic [15:0] dout, input logic ch);
    bus.req_valid = 1'b1; bus.req_wr = wr; bus.req_addr = a; bus.req_wdata = wd;
    cyc();
    bus.req_valid = 1'b0; bus.Done = 1'b1; bus.CacheHit = ch; bus.DataOut = dout;
    cyc();
    bus.Done = 1'b0; bus.CacheHit = 1'b0;
    #1;
  endtask
  initial begin
    int bad;
    bus.req_valid = 0; bus.req_wr = 0; bus.req_addr = 0; bus.req_wdata = 0; bus.dump_req = 0;
    bus.DataOut = 0; bus.Done = 0; bus.Stall = 0; bus.CacheHit = 0; bus.err = 0;
    cyc(); cyc();
    chk("rst_ready", 16'(bus.req_ready), 16'd1);
    chk("rst_rdwr", {14'd0, bus.Rd, bus.Wr}, 16'd0);
    chk("rst_resp", {14'd0, bus.resp_valid, bus.resp_err}, 16'd0);
    chk("rst_rdata", bus.resp_rdata, 16'h0000);
    chk("rst_hit", bus.hit_cnt, 16'd0);
    chk("rst_miss", bus.miss_cnt, 16'd0);
    chk("rst_addr", bus.Addr, 16'h0000);
    rst = 1'b0;
    bus.dump_req = 1'b1; #1;
    chk("dump_hi", 16'(bus.createdump), 16'd1);
    bus.dump_req = 1'b0; #1;
    chk("dump_lo", 16'(bus.createdump), 16'd0);
    chk("idle_nostall", 16'(bus.pipe_stall), 16'd0);
    bus.req_valid = 1'b1; bus.req_addr = 16'h0024; #1;
    chk("idle_stall", 16'(bus.pipe_stall), 16'd1);
    cyc();
    bus.req_valid = 1'b0; bus.Done = 1'b1; bus.CacheHit = 1'b1; bus.DataOut = 16'hBEEF; #1;
    chk("ld_rd", {14'd0, bus.Rd, bus.Wr}, 16'b10);
    chk("ld_addr", bus.Addr, 16'h0024);
    chk("ld_stall", 16'(bus.pipe_stall), 16'd1);
    cyc();
    bus.Done = 1'b0; bus.CacheHit = 1'b0; #1;
    chk("ld_valid", 16'(bus.resp_valid), 16'd1);
    chk("ld_rdata", bus.resp_rdata, 16'hBEEF);
    chk("ld_err", 16'(bus.resp_err), 16'd0);
    chk("ld_hit", bus.hit_cnt, 16'd1);
    chk("resp_ready", {14'd0, bus.req_ready, bus.pipe_stall}, 16'd0);
    cyc();
    chk("ld_done", {14'd0, bus.resp_valid, bus.req_ready}, 16'b01);
    bus.req_valid = 1'b1; bus.req_wr = 1'b1; bus.req_addr = 16'h1000; bus.req_wdata = 16'h1234;
    cyc();
    bus.req_valid = 1'b0; bus.req_addr = 16'hFFFE; bus.req_wdata = 16'h0; bus.DataOut = 16'hDEAD;
    for (int i = 0; i < 12; i++) begin
      bus.Done = (i == 11); #1;
      chk("st_wr", {14'd0, bus.Rd, bus.Wr}, 16'b01);
      chk("st_data", bus.DataIn, 16'h1234);
      chk("st_addr", bus.Addr, 16'h1000);
      cyc();
    end
    bus.Done = 1'b0; #1;
    chk("st_valid", 16'(bus.resp_valid), 16'd1);
    chk("st_err", 16'(bus.resp_err), 16'd0);
    chk("st_rdata", bus.resp_rdata, 16'hBEEF);
    chk("st_miss", bus.miss_cnt, 16'd1);
    chk("st_hit", bus.hit_cnt, 16'd1);
    cyc();
    bus.req_valid = 1'b1; bus.req_wr = 1'b0; bus.req_addr = 16'h0003; #1;
    chk("mis_idle_rdwr", {14'd0, bus.Rd, bus.Wr}, 16'd0);
    cyc();
    bus.req_valid = 1'b0; bus.Done = 1'b1; bus.CacheHit = 1'b1; #1;
    chk("mis_valid", {14'd0, bus.resp_valid, bus.resp_err}, 16'b11);
    chk("mis_rdwr", {14'd0, bus.Rd, bus.Wr}, 16'd0);
    cyc();
    chk("mis_ignore_hit", bus.hit_cnt, 16'd1);
    cyc();
    bus.Done = 1'b0; bus.CacheHit = 1'b0; #1;
    chk("mis_counts", {bus.hit_cnt[7:0], bus.miss_cnt[7:0]}, 16'h0101);
    bus.req_valid = 1'b1; bus.req_addr = 16'h0040;
    cyc();
    bus.req_valid = 1'b0; bad = 0;
    for (int k = 0; k < 64; k++) begin
      if (!(bus.Rd && !bus.resp_valid)) bad++;
      cyc();
    end
    chk("to_busy_cycles", 16'(bad), 16'd0);
    chk("to_valid", {14'd0, bus.resp_valid, bus.resp_err}, 16'b11);
    chk("to_rdata", bus.resp_rdata, 16'hBEEF);
    cyc();
    chk("to_idle", 16'(bus.req_ready), 16'd1);
    xfer(1'b0, 16'h0002, 16'h0, 16'h5A5A, 1'b0);
    chk("after_to_valid", {14'd0, bus.resp_valid, bus.resp_err}, 16'b10);
    chk("after_to_rdata", bus.resp_rdata, 16'h5A5A);
    chk("after_to_miss", bus.miss_cnt, 16'd2);
    cyc();
    bus.req_valid = 1'b1; bus.req_addr = 16'h0010;
    cyc();
    bus.req_valid = 1'b0; bus.err = 1'b1; bus.DataOut = 16'h1111;
    cyc();
    bus.err = 1'b0; #1;
    chk("errx_valid", {14'd0, bus.resp_valid, bus.resp_err}, 16'b11);
    chk("errx_rdata", bus.resp_rdata, 16'h5A5A);
    cyc();
    bus.err = 1'b1;
    xfer(1'b0, 16'h0020, 16'h0, 16'h7777, 1'b1);
    bus.err = 1'b0;
    chk("doneerr_err", {14'd0, bus.resp_valid, bus.resp_err}, 16'b11);
    chk("doneerr_rdata", bus.resp_rdata, 16'h7777);
    chk("doneerr_cnt", {bus.hit_cnt[7:0], bus.miss_cnt[7:0]}, 16'h0102);
    cyc();
    force dut.hit_q = 16'hFFFE;
    #1;
    release dut.hit_q;
    #1;
    chk("sat_preset", bus.hit_cnt, 16'hFFFE);
    xfer(1'b0, 16'h0030, 16'h0, 16'h0001, 1'b1);
    chk("sat_top", bus.hit_cnt, 16'hFFFF);
    cyc();
    xfer(1'b0, 16'h0030, 16'h0, 16'h0002, 1'b1);
    chk("sat_hold", bus.hit_cnt, 16'hFFFF);
    cyc();
    bus.req_valid = 1'b1; bus.req_wr = 1'b1; bus.req_addr = 16'h0200; bus.req_wdata = 16'hABCD;
    cyc();
    bus.req_valid = 1'b0; #1;
    chk("rb_wr", {14'd0, bus.Rd, bus.Wr}, 16'b01);
    bus.Done = 1'b1; rst = 1'b1; #1;
    chk("rb_rdwr", {14'd0, bus.Rd, bus.Wr}, 16'd0);
    chk("rb_ready", 16'(bus.req_ready), 16'd1);
    chk("rb_cnts", bus.hit_cnt | bus.miss_cnt, 16'd0);
    chk("rb_bus", bus.Addr | bus.DataIn, 16'd0);
    chk("rb_resp", {bus.resp_rdata[13:0], bus.resp_valid, bus.resp_err}, 16'd0);
    cyc();
    rst = 1'b0; bus.Done = 1'b0; bad = 0;
    for (int k = 0; k < 3; k++) begin
      if (bus.resp_valid) bad++;
      cyc();
    end
    chk("rb_noresp", 16'(bad), 16'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
